// File: rtl/csa_seq_adder_ctrl.sv
// Multi-cycle wide adder/subtractor: one 4-bit carry-select slice is stepped
// across the operands LSB->MSB, with the inter-slice carry held in a register.

module csa_slice4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       c3
);

   logic [2:0] lo;
   logic [1:0] up0;
   logic [1:0] up1;
   logic [1:0] top0;
   logic [1:0] top1;

   // Upper two bits are precomputed for both carry-in values, then picked by the low-pair carry.
   always_comb begin
      lo   = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
      up0  = {1'b0, a[2]} + {1'b0, b[2]};
      up1  = up0 + 2'b01;
      top0 = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, up0[1]};
      top1 = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, up1[1]};
      if (lo[2]) begin
         sum  = {top1[0], up1[0], lo[1:0]};
         cout = top1[1];
         c3   = up1[1];
      end else begin
         sum  = {top0[0], up0[0], lo[1:0]};
         cout = top0[1];
         c3   = up0[1];
      end
   end

endmodule

module csa_seq_adder_ctrl #(
   parameter int WIDTH  = 32,
   parameter int NSLICE = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   input  logic             flush,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_ovf,
   output logic             res_zero,
   output logic             busy
);

   localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [IDXW-1:0]  idx;
   logic             carry;
   logic             c_msb;
   logic             zero_reg;
   logic             valid_reg;

   logic [3:0]       sl_a;
   logic [3:0]       sl_b;
   logic [3:0]       sl_sum;
   logic             sl_cout;
   logic             sl_c3;
   logic [WIDTH-1:0] sum_next;

   // The zero flag must see the final nibble, so it is taken from the merged next sum.
   always_comb begin
      sl_a     = a_reg[{idx, 2'b00} +: 4];
      sl_b     = b_reg[{idx, 2'b00} +: 4];
      sum_next = sum_reg;
      sum_next[{idx, 2'b00} +: 4] = sl_sum;
   end

   csa_slice4 u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry),
      .sum  (sl_sum),
      .cout (sl_cout),
      .c3   (sl_c3)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         c_msb     <= 1'b0;
         zero_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else if (flush && (state != IDLE)) begin
         state     <= IDLE;
         valid_reg <= 1'b0;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  a_reg <= op_a;
                  b_reg <= op_b ^ {WIDTH{op_sub}};
                  carry <= op_sub;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum_reg <= sum_next;
               carry   <= sl_cout;
               if (idx == LAST_IDX) begin
                  c_msb     <= sl_c3;
                  zero_reg  <= (sum_next == '0);
                  valid_reg <= 1'b1;
                  idx       <= '0;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  valid_reg <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = (state == IDLE) & ~flush;
   assign busy      = (state != IDLE);
   assign res_valid = valid_reg;
   assign res_sum   = sum_reg;
   assign res_cout  = carry;
   assign res_ovf   = carry ^ c_msb;
   assign res_zero  = zero_reg;

endmodule

// File: tb/tb_csa_seq_adder_ctrl.sv
// Scoreboard bench for csa_seq_adder_ctrl: accepted requests push a model result,
// an independent monitor compares every presented result against the queue head.

module tb_csa_seq_adder_ctrl;

   localparam int W  = 32;
   localparam int NS = W / 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         op_sub = 1'b0;
   logic         flush = 1'b0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [W-1:0] res_sum;
   logic         res_cout;
   logic         res_ovf;
   logic         res_zero;
   logic         busy;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
      int           acc_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;

   csa_seq_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .flush     (flush),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_ovf   (res_ovf),
      .res_zero  (res_zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference result from plain integer arithmetic on the architectural operands.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input int acc);
      exp_t e;
      longint sa, sb, r, maxs, mins;
      longint unsigned ua, ub;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ua   = 64'(a);
      ub   = 64'(b);
      r    = sub ? (sa - sb) : (sa + sb);
      maxs = (longint'(1) <<< (W - 1)) - 1;
      mins = -(longint'(1) <<< (W - 1));
      e.sum     = r[W-1:0];
      e.ovf     = (r > maxs) || (r < mins);
      e.cout    = sub ? (a >= b) : (((ua + ub) >> W) != 0);
      e.zero    = (e.sum == '0);
      e.acc_cyc = acc;
      return e;
   endfunction

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("[TB] FAIL %s got=%0h required=%0h (cycle %0d)", name, got, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && req_valid && req_ready)
         sb_q.push_back(model(op_a, op_b, op_sub, cyc + 1));
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (res_valid) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_result got res_valid=1 required 0 (cycle %0d)", cyc);
            end else begin
               e = sb_q[0];
               if (!prev_valid)
                  check_output("latency", 64'(cyc - e.acc_cyc), 64'(NS));
               check_output("res_sum", 64'(res_sum), 64'(e.sum));
               check_output("res_cout", 64'(res_cout), 64'(e.cout));
               check_output("res_ovf", 64'(res_ovf), 64'(e.ovf));
               check_output("res_zero", 64'(res_zero), 64'(e.zero));
               if (res_ready && !flush)
                  void'(sb_q.pop_front());
            end
         end
         prev_valid = res_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns just after the accept edge; req_valid is left for the caller.
   task automatic wait_accept();
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         total++;
         bad++;
         $display("[TB] FAIL accept_timeout got req_ready=0 required 1");
      end
      tick();
   endtask

   task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      req_valid = 1'b1;
      op_a      = a;
      op_b      = b;
      op_sub    = sub;
      wait_accept();
      req_valid = 1'b0;
      op_a      = $urandom;
      op_b      = $urandom;
      op_sub    = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         res_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      res_ready = 1'b0;
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain_timeout got pending=%0d required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!res_valid && n < 30) begin
         tick();
         n++;
      end
      check_output("reach_done", 64'(res_valid), 64'(1));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [W-1:0] ra, rb;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_req_ready", 64'(req_ready), 64'(1));
      check_output("rst_res_valid", 64'(res_valid), 64'(0));
      check_output("rst_busy", 64'(busy), 64'(0));
      check_output("rst_res_sum", 64'(res_sum), 64'(0));
      check_output("rst_flags", 64'({res_cout, res_ovf, res_zero}), 64'(0));
      rst_n = 1'b1;
      tick();

      apply_stimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      drain();
      apply_stimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      drain();
      apply_stimulus(32'd5, 32'd7, 1'b1);
      drain();
      apply_stimulus(32'h8000_0000, 32'h0000_0001, 1'b1);
      drain();
      apply_stimulus(32'h0000_ABCD, 32'h0000_0000, 1'b1);
      drain();

      // Result held in DONE while a second request waits on the request side.
      req_valid = 1'b1;
      op_a = 32'h0000_1234;
      op_b = 32'h0000_4321;
      op_sub = 1'b0;
      wait_accept();
      op_a = 32'hDEAD_0000;
      op_b = 32'h0000_BEEF;
      op_sub = 1'b1;
      res_ready = 1'b0;
      wait_done();
      repeat (5) begin
         @(negedge clk);
         check_output("hold_req_ready", 64'(req_ready), 64'(0));
         check_output("hold_busy", 64'(busy), 64'(1));
      end
      tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      @(negedge clk);
      check_output("reaccept_ready", 64'(req_ready), 64'(1));
      tick();
      check_output("reaccept_busy", 64'(busy), 64'(1));
      req_valid = 1'b0;
      drain();

      req_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      check_output("flush_idle_ready", 64'(req_ready), 64'(0));
      tick();
      check_output("flush_idle_busy", 64'(busy), 64'(0));
      flush = 1'b0;
      req_valid = 1'b0;
      tick();

      req_valid = 1'b1;
      op_a = $urandom;
      op_b = $urandom;
      op_sub = 1'b0;
      wait_accept();
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 flush = 1'b1;
      tick();
      flush = 1'b0;
      sb_q.delete();
      check_output("flush_run_busy", 64'(busy), 64'(0));
      check_output("flush_run_valid", 64'(res_valid), 64'(0));
      repeat (12) tick();

      apply_stimulus($urandom, $urandom, 1'b1);
      wait_done();
      flush = 1'b1;
      res_ready = 1'b1;
      tick();
      flush = 1'b0;
      res_ready = 1'b0;
      sb_q.delete();
      check_output("flush_done_busy", 64'(busy), 64'(0));
      check_output("flush_done_valid", 64'(res_valid), 64'(0));
      tick();

      req_valid = 1'b1;
      op_a = $urandom;
      op_b = $urandom;
      op_sub = 1'b1;
      wait_accept();
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_output("rst_run_busy", 64'(busy), 64'(0));
      check_output("rst_run_valid", 64'(res_valid), 64'(0));
      check_output("rst_run_ready", 64'(req_ready), 64'(1));
      check_output("rst_run_sum", 64'(res_sum), 64'(0));
      sb_q.delete();
      #1 rst_n = 1'b1;
      repeat (12) tick();

      apply_stimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
      drain();

      for (int i = 0; i < 25; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = '0;
            1: rb = ra;
            2: rb = '1;
            3: ra = {1'b1, {(W - 1){1'b0}}};
            default: ;
         endcase
         apply_stimulus(ra, rb, 1'($urandom_range(0, 1)));
         drain();
      end

      repeat (3) tick();
      check_output("queue_empty", 64'(sb_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
